axi_write_data_channel: RTL and testbench
=========================================

Name:
axi_write_data_channel

Overview:
- AXI3 write-data (W) channel master: takes one burst of beats from a local source handshake and drives WDATA/WSTRB/WLAST/WVALID/WID to the slave.
- Sits directly upstream of the write-response channel block. Its `done` is the `go` of that block; its `WID` equals the ID that block expects on BID.
- Single outstanding burst; go/done handshake matches the response channel.

Parameters:
- DATA_WIDTH, 32, width of WDATA and src_data (multiple of 8)
- ID_WIDTH, 4, width of WID and txn_id
- LEN_WIDTH, 4, width of burst_len (AXI3 AWLEN; beats = burst_len+1, 1..16)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- go  in  1  start request, level; sampled in IDLE
- burst_len  in  LEN_WIDTH  beats minus one; latched on accepted go
- txn_id  in  ID_WIDTH  transaction ID; latched on accepted go
- src_data  in  DATA_WIDTH  next beat from local source
- src_valid  in  1  src_data valid
- src_ready  out  1  block accepts src_data this cycle
- WID  out  ID_WIDTH  latched txn_id
- WDATA  out  DATA_WIDTH  registered beat data
- WSTRB  out  DATA_WIDTH/8  byte strobes
- WLAST  out  1  final beat of burst
- WVALID  out  1  beat valid
- WREADY  in  1  slave accepts beat
- done  out  1  burst fully transferred
- beats_left  out  LEN_WIDTH  remaining beats after the current one
- current_state_out  out  3  debug state encoding

Behaviour:
- States and debug encoding: RESET=000, IDLE=001, FETCH=010, SEND=011, COMPLETE=100. Any unused encoding reads 111 and returns to RESET next cycle.
- Async reset (resetn=0):
  - state=RESET.
  - WID, WDATA, beats_left = 0.
  - WVALID, WLAST, src_ready, done = 0.
  - Applies immediately, including mid-burst. The partial burst is abandoned with no further W beats.
- RESET: unconditionally to IDLE on the next clk.
- IDLE:
  - If go=1, latch burst_len into beats_left and txn_id into WID, then go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - src_ready=1 (combinational from state).
  - On src_valid=1: register src_data into WDATA, set WVALID=1, set WLAST=(beats_left==0), go to SEND.
  - Without src_valid, stay in FETCH; WVALID stays 0.
- SEND:
  - WVALID=1; WDATA, WLAST and WID held stable until WREADY=1. This is the AXI rule: no retraction, no change while stalled.
  - On WREADY=1 with WLAST=0: decrement beats_left, clear WVALID, go to FETCH.
  - On WREADY=1 with WLAST=1: clear WVALID and WLAST, go to COMPLETE.
  - src_ready=0 throughout SEND.
  - Throughput: one beat per 2 cycles minimum.
- COMPLETE:
  - done=1 (registered, asserted the cycle after the last handshake).
  - Stays in COMPLETE while go=1. On go=0, go to IDLE and drop done.
- WSTRB: all ones, constant, independent of state.
- go is ignored outside IDLE. burst_len/txn_id changes are ignored after latch.
- burst_len=0: single beat with WLAST=1 on the first beat.
- beats_left never wraps: decrement happens only when WLAST=0, which implies beats_left>0.
- WREADY asserted while WVALID=0 is ignored. WREADY asserted before WVALID is legal.
- src_valid in any state other than FETCH is ignored (no capture).

Decomposition:
- Shared package axi_pkg:
  - State enum w_fsm_t with the fixed encodings above.
  - Constants AXI_LEN_WIDTH=4 and AXI_ID_WIDTH=4.
  - Debug encoding W_STATE_INVALID=3'b111.
- The write-response channel block uses the same package for its enum.
- No sub-module: one FSM, one down-counter, and the data/control registers in a single module.

Test Plan:
1. burst_len=3, txn_id=4'hA, src always valid with data 1,2,3,4, WREADY=1 -> four W beats in order, WID=A throughout, WLAST only on beat 4; done=1 one cycle after beat 4; done holds until go drops, then IDLE (current_state_out=001).
2. burst_len=0, data 32'hDEADBEEF, WREADY held 0 for 5 cycles then 1 -> WVALID=1, WLAST=1, WDATA=DEADBEEF stable all 5 stall cycles; one beat total; then COMPLETE (100).
3. burst_len=2, src_valid gaps of 3 cycles between beats -> src_ready=1 only in FETCH, WVALID=0 during gaps, beats_left reads 2,1,0 on successive beats, exactly 3 handshakes.
4. burst_len=15, WREADY random 50% -> 16 beats, data sequence 0..15 preserved, WLAST only on beat 16, no WVALID drop before WREADY.
5. resetn pulsed low mid-burst (after beat 2 of 8) -> outputs zero asynchronously; RESET then IDLE; no further beats; a new go with burst_len=1 completes normally.
6. go toggled during FETCH/SEND and burst_len/txn_id changed mid-burst -> ignored; beat count and WID unchanged from the latched values.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-data and write-response channel blocks.
// Contents:
//   AXI_LEN_WIDTH, AXI_ID_WIDTH : default AXI3 field widths
//   w_fsm_t                     : W-channel FSM state type with fixed encodings
//   W_STATE_INVALID             : debug value shown for any unused encoding
package axi_pkg;

  localparam int AXI_LEN_WIDTH = 4;
  localparam int AXI_ID_WIDTH  = 4;

  typedef enum logic [2:0] {
    W_RESET    = 3'b000,
    W_IDLE     = 3'b001,
    W_FETCH    = 3'b010,
    W_SEND     = 3'b011,
    W_COMPLETE = 3'b100
  } w_fsm_t;

  localparam logic [2:0] W_STATE_INVALID = 3'b111;

endpackage

// File: rtl/axi_write_data_channel.sv
// AXI3 write-data (W) channel master. Transfers one burst of burst_len+1 beats
// from a local valid/ready source to the slave, then raises done (which is the
// go of the downstream write-response block) until go is released.
// Ports:
//   clk, resetn           : clock, asynchronous active-low reset
//   go                    : level start request, only honoured in IDLE
//   burst_len, txn_id     : beats-minus-one and transaction ID, latched on go
//   src_data/src_valid    : local beat source
//   src_ready             : high while waiting for the next beat (FETCH)
//   WID/WDATA/WSTRB/WLAST/WVALID, WREADY : AXI3 W channel
//   done                  : burst complete, held while go stays high
//   beats_left            : beats remaining after the current one
//   current_state_out     : debug state encoding (111 for unused encodings)
module axi_write_data_channel
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int LEN_WIDTH  = AXI_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    go,
  input  logic [LEN_WIDTH-1:0]    burst_len,
  input  logic [ID_WIDTH-1:0]     txn_id,
  input  logic [DATA_WIDTH-1:0]   src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [ID_WIDTH-1:0]     WID,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  output logic                    done,
  output logic [LEN_WIDTH-1:0]    beats_left,
  output logic [2:0]              current_state_out
);

  w_fsm_t                  state_reg, state_next;
  logic [ID_WIDTH-1:0]     wid_reg, wid_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic                    wlast_reg, wlast_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    done_reg, done_next;
  logic [LEN_WIDTH-1:0]    left_reg, left_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= W_RESET;
      wid_reg    <= '0;
      wdata_reg  <= '0;
      wlast_reg  <= 1'b0;
      wvalid_reg <= 1'b0;
      done_reg   <= 1'b0;
      left_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      wid_reg    <= wid_next;
      wdata_reg  <= wdata_next;
      wlast_reg  <= wlast_next;
      wvalid_reg <= wvalid_next;
      done_reg   <= done_next;
      left_reg   <= left_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wid_next    = wid_reg;
    wdata_next  = wdata_reg;
    wlast_next  = wlast_reg;
    wvalid_next = wvalid_reg;
    done_next   = done_reg;
    left_next   = left_reg;

    case (state_reg)
      W_RESET: state_next = W_IDLE;

      W_IDLE: begin
        if (go) begin
          left_next  = burst_len;
          wid_next   = txn_id;
          state_next = W_FETCH;
        end
      end

      W_FETCH: begin
        if (src_valid) begin
          wdata_next  = src_data;
          wvalid_next = 1'b1;
          wlast_next  = (left_reg == '0);
          state_next  = W_SEND;
        end
      end

      // Beat registers are frozen here until the slave takes the beat.
      W_SEND: begin
        if (WREADY) begin
          wvalid_next = 1'b0;
          if (wlast_reg) begin
            wlast_next = 1'b0;
            done_next  = 1'b1;
            state_next = W_COMPLETE;
          end else begin
            // WLAST=0 guarantees left_reg>0, so this never wraps.
            left_next  = left_reg - LEN_WIDTH'(1);
            state_next = W_FETCH;
          end
        end
      end

      W_COMPLETE: begin
        if (!go) begin
          done_next  = 1'b0;
          state_next = W_IDLE;
        end
      end

      // Unused encodings: drop any beat in flight and restart cleanly.
      default: begin
        wvalid_next = 1'b0;
        wlast_next  = 1'b0;
        done_next   = 1'b0;
        state_next  = W_RESET;
      end
    endcase
  end

  always_comb begin
    case (state_reg)
      W_RESET, W_IDLE, W_FETCH, W_SEND, W_COMPLETE: current_state_out = state_reg;
      default: current_state_out = W_STATE_INVALID;
    endcase
  end

  assign src_ready  = (state_reg == W_FETCH);
  assign WID        = wid_reg;
  assign WDATA      = wdata_reg;
  assign WSTRB      = '1;
  assign WLAST      = wlast_reg;
  assign WVALID     = wvalid_reg;
  assign done       = done_reg;
  assign beats_left = left_reg;

endmodule

// File: tb/tb_axi_write_data_channel.sv
module tb_axi_write_data_channel;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        go = 1'b0;
  logic [3:0]  burst_len = '0;
  logic [3:0]  txn_id = '0;
  logic [31:0] src_data = '0;
  logic        src_valid = 1'b0;
  logic        src_ready;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic        done;
  logic [3:0]  beats_left;
  logic [2:0]  current_state_out;

  axi_write_data_channel dut (
    .clk(clk), .resetn(resetn), .go(go), .burst_len(burst_len), .txn_id(txn_id),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .done(done), .beats_left(beats_left),
    .current_state_out(current_state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
    logic [3:0]  left;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] src_q[$];
  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int stall_cycles = 0;
  int gap_cfg = 0;
  int wr_mode = 0;
  int stall_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Local source: presents queued beats, inserting gap_cfg idle cycles after
  // each accepted beat; presents junk while invalid.
  initial begin
    bit fire;
    int gap_cnt = 0;
    forever begin
      @(negedge clk);
      fire = src_valid && src_ready && resetn;
      @(posedge clk);
      #1;
      if (fire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap_cnt = gap_cfg;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      src_valid = (src_q.size() > 0) && (gap_cnt == 0);
      src_data  = src_valid ? src_q[0] : $urandom;
    end
  end

  // Slave ready: 0 = always ready, 1 = random 50%, 2 = stall 5 valid cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (wr_mode)
        0: WREADY = 1'b1;
        1: WREADY = 1'($urandom_range(0, 1));
        default: begin
          WREADY = (stall_cnt >= 5);
          if (WVALID) stall_cnt++;
        end
      endcase
    end
  end

  // Monitor / scoreboard: compares every W handshake with the expected queue
  // and checks AXI stability while the slave stalls.
  initial begin
    bit          have_stall = 0;
    logic [37:0] prev_beat = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        have_stall = 0;
      end else begin
        if (have_stall)
          chk("w_stable_while_stalled", {WVALID, WLAST, WID, WDATA}, prev_beat);
        if (src_ready)
          chk("src_ready_only_in_fetch", {WVALID, current_state_out}, {1'b0, 3'b010});
        if (WVALID && WREADY) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(WDATA), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("beat %0d id=%h data=%h last=%b left=%0d", beats_seen, WID, WDATA, WLAST, beats_left);
            chk("wdata", 64'(WDATA), 64'(e.data));
            chk("wlast", 64'(WLAST), 64'(e.last));
            chk("wid", 64'(WID), 64'(e.id));
            chk("beats_left", 64'(beats_left), 64'(e.left));
            chk("wstrb", 64'(WSTRB), 64'hF);
            beats_seen++;
          end
        end
        if (WVALID && !WREADY) stall_cycles++;
        have_stall = WVALID && !WREADY;
        prev_beat  = {WVALID, WLAST, WID, WDATA};
      end
    end
  end

  task automatic queue_burst(input int len, input logic [3:0] id, input bit rnd, input logic [31:0] base);
    logic [31:0] d;
    for (int i = 0; i <= len; i++) begin
      d = rnd ? 32'($urandom) : base + 32'(i);
      exp_q.push_back('{data: d, last: (i == len), id: id, left: 4'(len - i)});
      src_q.push_back(d);
    end
  endtask

  task automatic run_burst(input int len, input logic [3:0] id, input bit rnd, input logic [31:0] base,
                           input int gap, input int wmode, input bit toggle);
    int n = 0;
    gap_cfg = gap;
    wr_mode = wmode;
    stall_cnt = 0;
    beats_seen = 0;
    queue_burst(len, id, rnd, base);
    @(posedge clk);
    #1;
    burst_len = 4'(len);
    txn_id = id;
    go = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
      if (n++ > 3000) begin
        chk("burst_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        src_q.delete();
        break;
      end
      if (toggle) begin
        go = 1'($urandom_range(0, 1));
        burst_len = 4'($urandom);
        txn_id = 4'($urandom);
      end
    end
    go = 1'b1;
    chk("beat_count", 64'(beats_seen), 64'(len + 1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_held", {61'd0, done, current_state_out}, {61'd0, 1'b1, 3'b100});
    end
    @(posedge clk);
    #1;
    go = 1'b0;
    @(negedge clk);
    chk("done_until_go_drop", {61'd0, done, current_state_out}, {61'd0, 1'b1, 3'b100});
    @(negedge clk);
    chk("idle_after_done", {61'd0, done, current_state_out}, {61'd0, 1'b0, 3'b001});
  endtask

  initial begin
    int n;
    #1 resetn = 1'b0;
    #1;
    chk("reset_ctrl", {WVALID, WLAST, src_ready, done, WID, beats_left}, 12'd0);
    chk("reset_wdata", 64'(WDATA), 64'd0);
    chk("reset_state", 64'(current_state_out), 64'd0);
    chk("reset_wstrb", 64'(WSTRB), 64'hF);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("state_reset", 64'(current_state_out), 64'h0);
    @(negedge clk);
    chk("state_idle", 64'(current_state_out), 64'h1);

    // 1: four in-order beats, slave always ready
    run_burst(3, 4'hA, 1'b0, 32'd1, 0, 0, 1'b0);

    // 2: single beat stalled for five cycles
    stall_cycles = 0;
    run_burst(0, 4'h3, 1'b0, 32'hDEADBEEF, 0, 2, 1'b0);
    chk("stall_cycles", 64'(stall_cycles), 64'd5);

    // 3: source gaps of three cycles
    run_burst(2, 4'h5, 1'b1, 32'd0, 3, 0, 1'b0);

    // 4: sixteen beats with random slave backpressure
    run_burst(15, 4'hC, 1'b0, 32'd0, 0, 1, 1'b0);

    // 5: reset after beat 2 of 8
    gap_cfg = 0;
    wr_mode = 0;
    beats_seen = 0;
    queue_burst(7, 4'h7, 1'b1, 32'd0);
    @(posedge clk);
    #1;
    burst_len = 4'd7;
    txn_id = 4'h7;
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    n = 0;
    while (beats_seen < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("reset_test_reached_beat2", 64'(beats_seen), 64'd2);
    #3 resetn = 1'b0;
    #1;
    chk("midburst_reset_ctrl", {WVALID, WLAST, src_ready, done, WID, beats_left}, 12'd0);
    chk("midburst_reset_wdata", 64'(WDATA), 64'd0);
    chk("midburst_reset_state", 64'(current_state_out), 64'd0);
    exp_q.delete();
    src_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_state", 64'(current_state_out), 64'h0);
    @(negedge clk);
    chk("post_reset_idle", 64'(current_state_out), 64'h1);
    repeat (10) @(negedge clk);
    chk("no_beats_after_reset", 64'(beats_seen), 64'd2);
    run_burst(1, 4'h9, 1'b1, 32'd0, 0, 0, 1'b0);

    // 6: go, burst_len and txn_id churned after the burst is latched
    run_burst(5, 4'h6, 1'b1, 32'd0, 1, 1, 1'b1);
    run_burst(2, 4'hE, 1'b1, 32'd0, 0, 1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
